move_collector: RTL

- Downstream stage of the 64 square units. After every square asserts done, it walks squares 0..63 in order and drains each square's move FIFO through an external 64:1 mux that it steers with sq_sel.
- Each 160-bit FIFO word is unpacked into up to 8 19-bit moves. Invalid slots (bit 18 set) are discarded and valid moves are streamed out one per cycle over a valid/ready handshake to the move-list/search stage.
- The block counts emitted moves and flags overflow.

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/slot_picker.sv | 20 ++
 rtl/move_collector.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the move-generation datapath: piece/colour codes,
// move and FIFO word geometry, move flag bit positions, the invalid-move
// word and the move collector state encoding.
package chess_pkg;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PAWN    = 3'd1,
    KNIGHT  = 3'd2,
    BISHOP  = 3'd3,
    ROOK    = 3'd4,
    QUEEN   = 3'd5,
    KING    = 3'd6,
    NOTUSED = 3'd7
  } piece_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } colour_t;

  localparam int MOVE_W = 19;
  localparam int FIFO_W = 160;
  localparam int SLOTS  = 8;

  localparam int FLG_INVALID = 18;
  localparam int FLG_PROMOTE = 17;
  localparam int FLG_PAWN    = 16;
  localparam int FLG_PAWN2   = 15;
  localparam int FLG_EP      = 14;
  localparam int FLG_CASTLE  = 13;
  localparam int FLG_CAPTURE = 12;

  // Filler word for unused FIFO slots: only the invalid flag is set.
  localparam logic [MOVE_W-1:0] IMOV = 19'h40000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_SEL  = 3'd2,
    ST_LAT  = 3'd3,
    ST_UNPK = 3'd4,
    ST_NEXT = 3'd5,
    ST_FIN  = 3'd6
  } coll_state_t;

  // Extract move slot k from the packed slot area of a FIFO word.
  function automatic logic [MOVE_W-1:0] get_slot(input logic [SLOTS*MOVE_W-1:0] w,
                                                 input logic [2:0] k);
    return w[k*MOVE_W +: MOVE_W];
  endfunction

endpackage

// File: rtl/slot_picker.sv
// Priority picker: lowest set bit of the pending-slot mask and a flag
// telling whether any slot is still pending.
module slot_picker
  import chess_pkg::*;
(
  input  logic [SLOTS-1:0] mask,
  output logic [2:0]       idx,
  output logic             any
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = |mask;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (mask[k]) idx = k[2:0];
    end
  end

endmodule

// File: rtl/move_collector.sv
// Move collector: after all square units finish, walks squares 0..NSQ-1,
// drains each square FIFO through the external mux selected by sq_sel,
// unpacks up to 8 moves per word and streams valid ones on mv_valid/mv_ready.
// Optional macro MOVE_COLLECTOR_STATS_EN adds the cap_count output.
module move_collector
  import chess_pkg::*;
#(
  parameter int NSQ       = 64,
  parameter int MAX_MOVES = 255,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sq_done_all,
  output logic [5:0]        sq_sel,
  input  logic              sq_fifo_empty,
  input  logic [FIFO_W-1:0] sq_fifo_data,
  output logic              sq_rden,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [MOVE_W-1:0] mv_data,
  output logic [CNT_W-1:0]  mv_count,
  output logic              overflow,
  output logic              busy,
  output logic              list_done
`ifdef MOVE_COLLECTOR_STATS_EN
  ,
  output logic [CNT_W-1:0]  cap_count
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);
  localparam logic [5:0]       LAST_SQ = 6'(NSQ - 1);

  coll_state_t              state_reg;
  logic [SLOTS*MOVE_W-1:0]  word_reg;
  logic [SLOTS-1:0]         mask_reg;
  logic [SLOTS-1:0]         lat_mask;
  logic [2:0]               pick_idx;
  logic                     pick_any;
  logic                     at_max;
  logic                     unused_fifo_bits;

  // Bits above the eight slots carry nothing for us.
  assign unused_fifo_bits = ^sq_fifo_data[FIFO_W-1:SLOTS*MOVE_W];

  // A slot is pending when its invalid flag is clear.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_mask
    assign lat_mask[gi] = ~sq_fifo_data[gi*MOVE_W + FLG_INVALID];
  end

  slot_picker u_slot_picker (
    .mask (mask_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign at_max = (mv_count == MAX_CNT);

  // Read strobe must land in the SEL cycle itself so the word is present in LAT.
  assign sq_rden  = (state_reg == ST_SEL) && !sq_fifo_empty;
  // Move outputs decode registered state only, so a stall never changes them.
  assign mv_valid = (state_reg == ST_UNPK) && pick_any && !at_max;
  assign mv_data  = mv_valid ? get_slot(word_reg, pick_idx) : '0;

  // Collection state machine with its registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      sq_sel    <= '0;
      word_reg  <= '0;
      mask_reg  <= '0;
      mv_count  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      list_done <= 1'b0;
`ifdef MOVE_COLLECTOR_STATS_EN
      cap_count <= '0;
`endif
    end else begin
      list_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_WAIT;
            busy      <= 1'b1;
            mv_count  <= '0;
            overflow  <= 1'b0;
            sq_sel    <= '0;
`ifdef MOVE_COLLECTOR_STATS_EN
            cap_count <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (sq_done_all) state_reg <= ST_SEL;
        end
        ST_SEL: begin
          state_reg <= sq_fifo_empty ? ST_NEXT : ST_LAT;
        end
        ST_LAT: begin
          word_reg  <= sq_fifo_data[SLOTS*MOVE_W-1:0];
          mask_reg  <= lat_mask;
          state_reg <= ST_UNPK;
        end
        ST_UNPK: begin
          if (!pick_any) begin
            // Same square again: its FIFO may hold further words.
            state_reg <= ST_SEL;
          end else if (at_max) begin
            // Budget exhausted: discard what is left but keep draining.
            mask_reg <= '0;
            overflow <= 1'b1;
          end else if (mv_ready) begin
            mask_reg[pick_idx] <= 1'b0;
            mv_count           <= mv_count + 1'b1;
`ifdef MOVE_COLLECTOR_STATS_EN
            if (mv_data[FLG_CAPTURE]) cap_count <= cap_count + 1'b1;
`endif
          end
        end
        ST_NEXT: begin
          if (sq_sel == LAST_SQ) begin
            state_reg <= ST_FIN;
            list_done <= 1'b1;
          end else begin
            sq_sel    <= sq_sel + 1'b1;
            state_reg <= ST_SEL;
          end
        end
        ST_FIN: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
